// File: rtl/eq_pkg.sv
// ============================================================================
// Module : eq_pkg
// Shared constants, gain type and controller state encoding for the EQ gain ramp.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package eq_pkg;
  localparam int GAIN_WIDTH = 8;
  localparam int NUM_BANDS  = 10;
  localparam int BAND_W     = $clog2(NUM_BANDS);

  typedef logic [GAIN_WIDTH-1:0] gain_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    COMMIT = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/eq_gain_stepper.sv
// ============================================================================
// Module : eq_gain_stepper
// Moves one gain code toward its target by at most STEP, clamping at the target.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module eq_gain_stepper
  import eq_pkg::*;
#(
  parameter int STEP = 1
) (
  input  gain_t i_cur,
  input  gain_t i_tgt,
  output gain_t o_next
);

  localparam gain_t c_STEP = gain_t'(STEP);

  logic  w_up;
  gain_t w_diff;

  assign w_up   = (i_tgt > i_cur);
  assign w_diff = w_up ? (i_tgt - i_cur) : (i_cur - i_tgt);

  // Only step by STEP when the gap exceeds it, so the result can neither wrap nor overshoot.
  always_comb begin
    o_next = i_tgt;
    if (w_diff > c_STEP) begin
      o_next = w_up ? (i_cur + c_STEP) : (i_cur - c_STEP);
    end
  end

endmodule

`default_nettype wire

// File: rtl/eq_gain_ramp_ctrl.sv
// ============================================================================
// Module : eq_gain_ramp_ctrl
// Per-band EQ gain targets with one shared stepper sweeping all bands each sample.
// Optional feature macro: EQ_GAIN_MUTE_EN (adds a mute input ramping all gains to 0).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module eq_gain_ramp_ctrl
  import eq_pkg::*;
#(
  parameter int STEP       = 1,
  parameter int RESET_GAIN = 128
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sample_tick,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [BAND_W-1:0]               cmd_band,
  input  logic [GAIN_WIDTH-1:0]           cmd_gain,
`ifdef EQ_GAIN_MUTE_EN
  input  logic                            mute,
`endif
  output logic [NUM_BANDS*GAIN_WIDTH-1:0] gains_o,
  output logic                            settled,
  output logic                            tick_overrun,
  output logic                            cmd_err
);

  localparam gain_t             c_RESET_GAIN = gain_t'(RESET_GAIN);
  localparam logic [BAND_W-1:0] c_LAST_IDX   = BAND_W'(NUM_BANDS - 1);

  state_t                          r_state;
  logic [BAND_W-1:0]               r_idx;
  gain_t                           r_tgt [NUM_BANDS];
  gain_t                           r_cur [NUM_BANDS];
  logic [NUM_BANDS*GAIN_WIDTH-1:0] r_gains;
  logic                            r_ready;
  logic                            r_settled;
  logic                            r_overrun;
  logic                            r_err;
  logic                            r_mute_lat;

  logic  w_mute;
  logic  w_accept;
  logic  w_band_ok;
  logic  w_tgt_change;
  logic  w_all_eq;
  gain_t w_eff_tgt;
  gain_t w_next;

`ifdef EQ_GAIN_MUTE_EN
  assign w_mute = mute;
`else
  assign w_mute = 1'b0;
`endif

  assign w_accept     = cmd_valid & r_ready;
  assign w_band_ok    = (cmd_band <= c_LAST_IDX);
  assign w_tgt_change = w_accept & w_band_ok & (cmd_gain != r_tgt[cmd_band]);
  assign w_eff_tgt    = w_mute ? '0 : r_tgt[r_idx];

  // Mute as seen by the sweep is what COMMIT must compare against.
  always_comb begin
    w_all_eq = 1'b1;
    for (int i = 0; i < NUM_BANDS; i++) begin
      if (r_cur[i] != (r_mute_lat ? gain_t'(0) : r_tgt[i])) begin
        w_all_eq = 1'b0;
      end
    end
  end

  eq_gain_stepper #(
    .STEP (STEP)
  ) u_stepper (
    .i_cur  (r_cur[r_idx]),
    .i_tgt  (w_eff_tgt),
    .o_next (w_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_ready    <= 1'b0;
      r_settled  <= 1'b1;
      r_overrun  <= 1'b0;
      r_err      <= 1'b0;
      r_mute_lat <= 1'b0;
      r_gains    <= {NUM_BANDS{c_RESET_GAIN}};
      for (int i = 0; i < NUM_BANDS; i++) begin
        r_tgt[i] <= c_RESET_GAIN;
        r_cur[i] <= c_RESET_GAIN;
      end
    end else begin
      if (w_accept) begin
        if (w_band_ok) begin
          r_tgt[cmd_band] <= cmd_gain;
        end else begin
          r_err <= 1'b1;
        end
      end

      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (w_tgt_change) begin
            r_settled <= 1'b0;
          end
          if (sample_tick) begin
            r_state <= SWEEP;
            r_idx   <= '0;
            r_ready <= 1'b0;
          end
        end

        SWEEP: begin
          r_cur[r_idx] <= w_next;
          r_mute_lat   <= w_mute;
          if (sample_tick) begin
            r_overrun <= 1'b1;
          end
          if (r_idx == c_LAST_IDX) begin
            r_state <= COMMIT;
            r_idx   <= '0;
            r_ready <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        COMMIT: begin
          for (int i = 0; i < NUM_BANDS; i++) begin
            r_gains[i*GAIN_WIDTH +: GAIN_WIDTH] <= r_cur[i];
          end
          r_settled <= w_all_eq & ~w_tgt_change;
          if (sample_tick) begin
            r_overrun <= 1'b1;
          end
          r_state <= IDLE;
          r_ready <= 1'b1;
        end

        default: begin
          r_state <= IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign cmd_ready    = r_ready;
  assign gains_o      = r_gains;
  assign settled      = r_settled;
  assign tick_overrun = r_overrun;
  assign cmd_err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_eq_gain_ramp_ctrl.sv
// ============================================================================
// Module : tb_eq_gain_ramp_ctrl
// Bench for eq_gain_ramp_ctrl: STEP=1 and STEP=4 instances driven in lockstep.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_eq_gain_ramp_ctrl;
  import eq_pkg::*;

  localparam int VW = NUM_BANDS * GAIN_WIDTH;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sample_tick = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [BAND_W-1:0] cmd_band = '0;
  gain_t             cmd_gain = '0;
`ifdef EQ_GAIN_MUTE_EN
  logic              mute = 1'b0;
`endif

  logic          rdy1, rdy4, set1, set4, ovr1, ovr4, err1, err4;
  logic [VW-1:0] g1, g4;

  int n_checks   = 0;
  int n_failures = 0;

  always #5 clk = ~clk;

  eq_gain_ramp_ctrl #(.STEP(1), .RESET_GAIN(128)) u_dut1 (
    .clk          (clk),
    .rst          (rst),
    .sample_tick  (sample_tick),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (rdy1),
    .cmd_band     (cmd_band),
    .cmd_gain     (cmd_gain),
`ifdef EQ_GAIN_MUTE_EN
    .mute         (mute),
`endif
    .gains_o      (g1),
    .settled      (set1),
    .tick_overrun (ovr1),
    .cmd_err      (err1)
  );

  eq_gain_ramp_ctrl #(.STEP(4), .RESET_GAIN(128)) u_dut4 (
    .clk          (clk),
    .rst          (rst),
    .sample_tick  (sample_tick),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (rdy4),
    .cmd_band     (cmd_band),
    .cmd_gain     (cmd_gain),
`ifdef EQ_GAIN_MUTE_EN
    .mute         (mute),
`endif
    .gains_o      (g4),
    .settled      (set4),
    .tick_overrun (ovr4),
    .cmd_err      (err4)
  );

  typedef struct {
    logic              cmd_en;
    logic [BAND_W-1:0] band;
    gain_t             gain;
    int                chk;
    gain_t             pre1;
    gain_t             exp1;
    logic              s1;
    gain_t             exp4;
    logic              s4;
  } vec_t;

  vec_t tbl [7];

  function automatic gain_t band_of(input logic [VW-1:0] v, input int b);
    return v[b*GAIN_WIDTH +: GAIN_WIDTH];
  endfunction

  function automatic logic [VW-1:0] all_of(input gain_t g);
    return {NUM_BANDS{g}};
  endfunction

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_failures++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chkg(input string nm, input gain_t act, input gain_t exp);
    n_checks++;
    if (act !== exp) begin
      n_failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Leaves the bench on the negedge just after the edge that sampled the tick.
  task automatic pulse_tick();
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic tick_commit();
    pulse_tick();
    repeat (11) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [BAND_W-1:0] b, input gain_t g);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_band  = b;
    cmd_gain  = g;
    for (int n = 0; n < 40 && !rdy1; n++) @(negedge clk);
    chkb("cmd_handshake", rdy1, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] expv;
    int            zeros;
    int            e4;

    tbl[0] = '{1'b0, 4'd0, 8'd0,   0, 8'd128, 8'd129, 1'b0, 8'd131, 1'b1};
    tbl[1] = '{1'b0, 4'd0, 8'd0,   0, 8'd129, 8'd130, 1'b0, 8'd131, 1'b1};
    tbl[2] = '{1'b0, 4'd0, 8'd0,   0, 8'd130, 8'd131, 1'b1, 8'd131, 1'b1};
    tbl[3] = '{1'b0, 4'd0, 8'd0,   0, 8'd131, 8'd131, 1'b1, 8'd131, 1'b1};
    tbl[4] = '{1'b0, 4'd0, 8'd0,   0, 8'd131, 8'd131, 1'b1, 8'd131, 1'b1};
    tbl[5] = '{1'b1, 4'd9, 8'd130, 9, 8'd128, 8'd129, 1'b0, 8'd130, 1'b1};
    tbl[6] = '{1'b0, 4'd0, 8'd0,   9, 8'd129, 8'd130, 1'b1, 8'd130, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chkv("reset_gains1", g1, all_of(8'd128));
    chkv("reset_gains4", g4, all_of(8'd128));
    chkb("reset_ready", rdy1, 1'b0);
    chkb("reset_settled", set1, 1'b1);
    chkb("reset_overrun", ovr1, 1'b0);
    chkb("reset_err", err1, 1'b0);
    rst = 1'b0;

    // Idle ticks with no commands
    repeat (3) tick_commit();
    chkv("idle_gains1", g1, all_of(8'd128));
    chkv("idle_gains4", g4, all_of(8'd128));
    chkb("idle_settled", set1, 1'b1);
    chkb("idle_overrun", ovr1, 1'b0);
    chkb("idle_err", err1, 1'b0);
    chkb("idle_ready", rdy1, 1'b1);

    // Ramp band0 to 131; settled must drop on the edge after the command
    send_cmd(4'd0, 8'd131);
    chkb("cmd_settled_drop1", set1, 1'b0);
    chkb("cmd_settled_drop4", set4, 1'b0);

    for (int r = 0; r < 7; r++) begin
      if (tbl[r].cmd_en) send_cmd(tbl[r].band, tbl[r].gain);
      pulse_tick();
      repeat (10) @(negedge clk);
      chkg($sformatf("row%0d_pre_commit", r), band_of(g1, tbl[r].chk), tbl[r].pre1);
      @(negedge clk);
      chkg($sformatf("row%0d_gain1", r), band_of(g1, tbl[r].chk), tbl[r].exp1);
      chkb($sformatf("row%0d_settled1", r), set1, tbl[r].s1);
      chkg($sformatf("row%0d_gain4", r), band_of(g4, tbl[r].chk), tbl[r].exp4);
      chkb($sformatf("row%0d_settled4", r), set4, tbl[r].s4);
    end

    // Band9 ramps down to 0: STEP=4 lands exactly on 0 without wrapping
    send_cmd(4'd9, 8'd0);
    for (int k = 1; k <= 34; k++) begin
      tick_commit();
      e4 = 130 - 4 * k;
      if (e4 < 0) e4 = 0;
      chkg($sformatf("down_k%0d_gain4", k), band_of(g4, 9), gain_t'(e4));
      chkg($sformatf("down_k%0d_gain1", k), band_of(g1, 9), gain_t'(130 - k));
    end
    chkb("down_settled4", set4, 1'b1);
    chkb("down_settled1", set1, 1'b0);

    // Tick during SWEEP is dropped; ready low for exactly NUM_BANDS cycles
    pulse_tick();
    zeros = 0;
    for (int c = 0; c < 24; c++) begin
      if (!rdy1) zeros++;
      if (c == 2) sample_tick = 1'b1;
      if (c == 3) sample_tick = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (zeros != NUM_BANDS) begin
      n_failures++;
      $display("FAIL ready_low_cycles: got %0d expected %0d", zeros, NUM_BANDS);
    end
    chkb("overrun1", ovr1, 1'b1);
    chkb("overrun4", ovr4, 1'b1);
    chkg("overrun_one_sweep", band_of(g1, 9), 8'd95);

    // Out-of-range band: handshake completes, nothing written, cmd_err sticky
    send_cmd(4'd12, 8'd55);
    chkb("bad_band_err1", err1, 1'b1);
    chkb("bad_band_err4", err4, 1'b1);
    chkb("bad_band_settled4", set4, 1'b1);
    tick_commit();
    expv = all_of(8'd128);
    expv[0*GAIN_WIDTH +: GAIN_WIDTH] = 8'd131;
    expv[9*GAIN_WIDTH +: GAIN_WIDTH] = 8'd0;
    chkv("bad_band_gains4", g4, expv);
    chkb("bad_band_settled4_after", set4, 1'b1);
    chkb("err_still_set", err1, 1'b1);

    // Command and tick on the same IDLE edge
    @(negedge clk);
    chkb("same_edge_ready", rdy1, 1'b1);
    cmd_valid   = 1'b1;
    cmd_band    = 4'd5;
    cmd_gain    = 8'd140;
    sample_tick = 1'b1;
    @(negedge clk);
    cmd_valid   = 1'b0;
    sample_tick = 1'b0;
    repeat (11) @(negedge clk);
    chkg("same_edge_gain4", band_of(g4, 5), 8'd132);
    chkg("same_edge_gain1", band_of(g1, 5), 8'd129);
    chkb("same_edge_settled4", set4, 1'b0);

    // Reset mid-sweep right after band3 has been updated
    pulse_tick();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chkv("midreset_gains1", g1, all_of(8'd128));
    chkv("midreset_gains4", g4, all_of(8'd128));
    chkb("midreset_settled", set1, 1'b1);
    chkb("midreset_ready", rdy1, 1'b0);
    chkb("midreset_overrun", ovr1, 1'b0);
    chkb("midreset_err", err4, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick_commit();
    chkv("postreset_gains4", g4, all_of(8'd128));
    chkv("postreset_gains1", g1, all_of(8'd128));
    chkb("postreset_settled4", set4, 1'b1);

`ifdef EQ_GAIN_MUTE_EN
    // Mute ramps everything to 0; targets stay writable and are restored on release
    mute = 1'b1;
    send_cmd(4'd2, 8'd136);
    repeat (32) tick_commit();
    chkv("mute_gains4", g4, all_of(8'd0));
    chkb("mute_settled4", set4, 1'b1);
    mute = 1'b0;
    repeat (34) tick_commit();
    expv = all_of(8'd128);
    expv[2*GAIN_WIDTH +: GAIN_WIDTH] = 8'd136;
    chkv("unmute_gains4", g4, expv);
    chkb("unmute_settled4", set4, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule

`default_nettype wire
